// File: rtl/game_pkg.sv
// game_pkg: shared types and helpers for the scene engine.
//   game_state_t : MENU / PLAY / WON / LOST encoding, also driven on the state port
//   COL_*        : 24-bit {r,g,b} colour constants
//   lane_next    : one scroll step of an obstacle lane, including wrap-around
package game_pkg;

    typedef enum logic [1:0] {
        MENU = 2'd0,
        PLAY = 2'd1,
        WON  = 2'd2,
        LOST = 2'd3
    } game_state_t;

    localparam logic [23:0] COL_BG       = 24'h7209AA;
    localparam logic [23:0] COL_PLAYER   = 24'hFF0000;
    localparam logic [23:0] COL_OBS_EVEN = 24'h000000;
    localparam logic [23:0] COL_OBS_ODD  = 24'hFFFFFF;
    localparam logic [23:0] COL_GROUND   = 24'h000000;
    localparam logic [23:0] COL_WIN      = 24'h00FF00;
    localparam logic [23:0] COL_LOSE     = 24'hFF0000;
    localparam logic [23:0] COL_BLANK    = 24'h000000;

    // Move a lane left by step; a lane that would go below zero re-enters
    // from beyond the right edge (span = visible width + obstacle width),
    // keeping its sub-step phase so spacing between lanes is preserved.
    function automatic logic [10:0] lane_next(input logic [10:0] pos,
                                              input logic [10:0] step,
                                              input logic [10:0] span);
        logic [10:0] nxt;
        if (pos < step) begin
            nxt = pos + span - step;
        end else begin
            nxt = pos - step;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/obstacle_lane.sv
// obstacle_lane: one horizontally scrolling obstacle.
//   clk, reset  : system clock, asynchronous active-low reset
//   reload      : return the lane to its start position (INIT_X)
//   advance     : scroll one step left this cycle (with wrap)
//   x, y        : current pixel coordinate
//   hit         : current pixel lies inside this obstacle's box
module obstacle_lane
    import game_pkg::*;
#(
    parameter int          H_ACTIVE = 640,
    parameter int          GROUND_Y = 400,
    parameter int          OBS_W    = 30,
    parameter int          OBS_H    = 40,
    parameter int          STEP     = 10,
    parameter logic [10:0] INIT_X   = 11'd640
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reload,
    input  logic       advance,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       hit
);

    localparam logic [10:0] H_C      = 11'(H_ACTIVE);
    localparam logic [10:0] GROUND_C = 11'(GROUND_Y);
    localparam logic [10:0] TOP_C    = 11'(GROUND_Y - OBS_H);
    localparam logic [10:0] OBS_W_C  = 11'(OBS_W);
    localparam logic [10:0] STEP_C   = 11'(STEP);
    localparam logic [10:0] SPAN_C   = 11'(H_ACTIVE + OBS_W);

    logic [10:0] obs_x_r;
    logic [10:0] x_ext_s;
    logic [10:0] y_ext_s;

    assign x_ext_s = {1'b0, x};
    assign y_ext_s = {1'b0, y};

    // Lane position: start slot on reset/reload, one wrapped step per advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            obs_x_r <= INIT_X;
        end else if (reload) begin
            obs_x_r <= INIT_X;
        end else if (advance) begin
            obs_x_r <= lane_next(obs_x_r, STEP_C, SPAN_C);
        end else begin
            obs_x_r <= obs_x_r;
        end
    end

    // Box test; the lane may sit off-screen, so clip to the visible width.
    always_comb begin
        hit = 1'b0;
        if ((x_ext_s >= obs_x_r) && (x_ext_s < obs_x_r + OBS_W_C) &&
            (y_ext_s >= TOP_C) && (y_ext_s < GROUND_C) && (x_ext_s < H_C)) begin
            hit = 1'b1;
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/scene_engine.sv
// scene_engine: scrolling-obstacle game scene with collision and game FSM.
//   clk, reset     : system clock, asynchronous active-low reset
//   x, y           : pixel coordinate from the VGA timing controller
//   game_tick      : one-cycle motion strobe
//   start          : one-cycle menu/restart request
//   height         : player lift above ground (clamped so the player stays on screen)
//   r, g, b        : registered pixel colour, one cycle after x/y
//   state          : current game_state_t
//   win, dead      : one-cycle pulses on entry to WON / LOST
module scene_engine
    import game_pkg::*;
#(
    parameter int NUM_OBS     = 4,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int GROUND_Y    = 400,
    parameter int PLAYER_X    = 220,
    parameter int PLAYER_W    = 30,
    parameter int PLAYER_H    = 40,
    parameter int OBS_W       = 30,
    parameter int OBS_H       = 40,
    parameter int OBS_SPACING = 160,
    parameter int STEP        = 10,
    parameter int WIN_TICKS   = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       game_tick,
    input  logic       start,
    input  logic [9:0] height,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic [1:0] state,
    output logic       win,
    output logic       dead
);

    localparam int          TICK_W   = $clog2(WIN_TICKS + 1);
    localparam logic [TICK_W-1:0] LAST_TICK_C = TICK_W'(WIN_TICKS - 1);
    localparam logic [10:0] H_C      = 11'(H_ACTIVE);
    localparam logic [10:0] V_C      = 11'(V_ACTIVE);
    localparam logic [10:0] GROUND_C = 11'(GROUND_Y);
    localparam logic [10:0] PX_L_C   = 11'(PLAYER_X);
    localparam logic [10:0] PX_R_C   = 11'(PLAYER_X + PLAYER_W);
    localparam logic [10:0] PH_C     = 11'(PLAYER_H);
    localparam logic [10:0] H_MAX_C  = 11'(GROUND_Y - PLAYER_H);

    game_state_t        state_r, next_state_s;
    logic [TICK_W-1:0]  tick_cnt_r;
    logic [NUM_OBS-1:0] obs_hit_s;
    logic [10:0]        x_ext_s, y_ext_s, h_s, bottom_s, top_s;
    logic               reload_s, advance_s, active_s, player_hit_s;
    logic               collide_s, win_cond_s;
    logic [23:0]        obs_col_s, colour_s, rgb_r;
    logic               win_r, dead_r;

    assign x_ext_s   = {1'b0, x};
    assign y_ext_s   = {1'b0, y};
    assign active_s  = (x_ext_s < H_C) && (y_ext_s < V_C);
    assign reload_s  = (state_r == MENU) && start;
    assign advance_s = (state_r == PLAY) && game_tick;

    for (genvar i = 0; i < NUM_OBS; i++) begin : g_lane
        obstacle_lane #(
            .H_ACTIVE (H_ACTIVE),
            .GROUND_Y (GROUND_Y),
            .OBS_W    (OBS_W),
            .OBS_H    (OBS_H),
            .STEP     (STEP),
            .INIT_X   (11'(H_ACTIVE + i * OBS_SPACING))
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .reload  (reload_s),
            .advance (advance_s),
            .x       (x),
            .y       (y),
            .hit     (obs_hit_s[i])
        );
    end

    // Player box; lift is clamped so the box top never goes above line 0.
    always_comb begin
        h_s = {1'b0, height};
        if ({1'b0, height} > H_MAX_C) begin
            h_s = H_MAX_C;
        end else begin
            h_s = {1'b0, height};
        end
        bottom_s     = GROUND_C - h_s;
        top_s        = bottom_s - PH_C;
        player_hit_s = (x_ext_s >= PX_L_C) && (x_ext_s < PX_R_C) &&
                       (y_ext_s >= top_s) && (y_ext_s < bottom_s);
    end

    assign collide_s  = (state_r == PLAY) && active_s && player_hit_s && (|obs_hit_s);
    assign win_cond_s = advance_s && (tick_cnt_r == LAST_TICK_C);

    // Next-state logic; a collision outranks a win on the same edge.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            MENU: begin
                if (start) next_state_s = PLAY;
                else       next_state_s = state_r;
            end
            PLAY: begin
                if (collide_s)       next_state_s = LOST;
                else if (win_cond_s) next_state_s = WON;
                else                 next_state_s = state_r;
            end
            WON, LOST: begin
                if (start) next_state_s = MENU;
                else       next_state_s = state_r;
            end
            default: next_state_s = MENU;
        endcase
    end

    // Lowest-numbered obstacle wins where lanes overlap.
    always_comb begin
        obs_col_s = COL_BG;
        for (int i = NUM_OBS - 32'sd1; i >= 32'sd0; i--) begin
            if (obs_hit_s[i]) begin
                obs_col_s = (i[0] == 1'b0) ? COL_OBS_EVEN : COL_OBS_ODD;
            end else begin
                obs_col_s = obs_col_s;
            end
        end
    end

    // Pixel colour from current state and coordinate, before registering.
    always_comb begin
        colour_s = COL_BLANK;
        if (!active_s) begin
            colour_s = COL_BLANK;
        end else begin
            case (state_r)
                MENU: colour_s = COL_BLANK;
                WON:  colour_s = COL_WIN;
                LOST: colour_s = COL_LOSE;
                PLAY: begin
                    if (y_ext_s >= GROUND_C) colour_s = COL_GROUND;
                    else if (|obs_hit_s)     colour_s = obs_col_s;
                    else if (player_hit_s)   colour_s = COL_PLAYER;
                    else                     colour_s = COL_BG;
                end
                default: colour_s = COL_BLANK;
            endcase
        end
    end

    // Ticks survived in the current game; cleared when a game starts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_r <= '0;
        end else if (reload_s) begin
            tick_cnt_r <= '0;
        end else if (advance_s) begin
            tick_cnt_r <= tick_cnt_r + 1'b1;
        end else begin
            tick_cnt_r <= tick_cnt_r;
        end
    end

    // State register, entry pulses and colour output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= MENU;
            win_r   <= 1'b0;
            dead_r  <= 1'b0;
            rgb_r   <= COL_BLANK;
        end else begin
            state_r <= next_state_s;
            win_r   <= (state_r == PLAY) && (next_state_s == WON);
            dead_r  <= (state_r == PLAY) && (next_state_s == LOST);
            rgb_r   <= colour_s;
        end
    end

    assign r     = rgb_r[23:16];
    assign g     = rgb_r[15:8];
    assign b     = rgb_r[7:0];
    assign state = state_r;
    assign win   = win_r;
    assign dead  = dead_r;

endmodule

// File: tb/tb_scene_engine.sv
// tb_scene_engine: directed-vector bench for scene_engine (WIN_TICKS = 74).
// Lane i starts at 640 + 160*i and moves 10 px per tick; lane 0 wraps from 0
// to 660 on its 65th tick. Expected colours/states are hand-computed.
module tb_scene_engine;
    import game_pkg::*;

    localparam int WIN_TICKS_TB = 74;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] x, y, height;
    logic       game_tick, start;
    logic [7:0] r, g, b;
    logic [1:0] state;
    logic       win, dead;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    scene_engine #(.WIN_TICKS(WIN_TICKS_TB)) dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .game_tick (game_tick),
        .start     (start),
        .height    (height),
        .r         (r),
        .g         (g),
        .b         (b),
        .state     (state),
        .win       (win),
        .dead      (dead)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input string tag, input logic [9:0] px, input logic [9:0] py,
                       input logic [23:0] exp);
        x = px;
        y = py;
        step();
        check_eq(tag, {8'h00, r, g, b}, {8'h00, exp});
    endtask

    task automatic ticks(input int n);
        game_tick = 1'b1;
        repeat (n) step();
        game_tick = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; x = 10'd300; y = 10'd200; height = 10'd0;
        game_tick = 1'b0; start = 1'b0;
        repeat (3) step();
        check_eq("rst_state", state, MENU);
        check_eq("rst_rgb", {8'h00, r, g, b}, 32'h0);
        check_eq("rst_win", win, 1'b0);
        check_eq("rst_dead", dead, 1'b0);
        reset = 1'b1;
        pix("menu_black", 10'd300, 10'd200, COL_BLANK);

        check_eq("wrap_fn", lane_next(11'd5, 11'd10, 11'd670), 32'd665);
        check_eq("step_fn", lane_next(11'd10, 11'd10, 11'd670), 32'd0);

        pulse_start();
        check_eq("to_play", state, PLAY);
        pix("play_bg", 10'd300, 10'd200, COL_BG);
        pulse_start();
        check_eq("start_ignored", state, PLAY);

        // 10 ticks: lane 0 at 540
        height = 10'd100; x = 10'd300; y = 10'd100;
        ticks(10);
        pix("lane0_left", 10'd540, 10'd380, COL_OBS_EVEN);
        pix("lane0_before", 10'd539, 10'd380, COL_BG);
        pix("lane0_last", 10'd569, 10'd380, COL_OBS_EVEN);
        pix("lane0_after", 10'd570, 10'd380, COL_BG);
        pix("obs_top", 10'd545, 10'd360, COL_OBS_EVEN);
        pix("obs_above", 10'd545, 10'd359, COL_BG);
        pix("player", 10'd230, 10'd280, COL_PLAYER);
        pix("player_bot", 10'd230, 10'd300, COL_BG);
        pix("player_top", 10'd230, 10'd259, COL_BG);
        pix("player_rt", 10'd249, 10'd280, COL_PLAYER);
        pix("player_rt_out", 10'd250, 10'd280, COL_BG);
        pix("ground", 10'd300, 10'd420, COL_GROUND);
        pix("out_x", 10'd640, 10'd100, COL_BLANK);
        pix("out_y", 10'd100, 10'd480, COL_BLANK);
        height = 10'd1000;
        pix("clamp_top", 10'd230, 10'd0, COL_PLAYER);
        pix("clamp_bot", 10'd230, 10'd40, COL_BG);
        height = 10'd100;

        // lane 0 sweeps under the lifted player: no collision
        x = 10'd235; y = 10'd380;
        ticks(35);
        check_eq("sweep_state", state, PLAY);
        check_eq("sweep_dead", dead, 1'b0);
        pix("lane1_odd", 10'd360, 10'd380, COL_OBS_ODD);
        pix("lane0_190", 10'd190, 10'd380, COL_OBS_EVEN);
        pix("lane0_end", 10'd220, 10'd380, COL_BG);

        // to 73 ticks: lane 0 wrapped (0 -> 660) and now at 580
        x = 10'd300; y = 10'd100;
        ticks(28);
        check_eq("pre_win_state", state, PLAY);
        check_eq("pre_win_win", win, 1'b0);
        pix("wrap_in", 10'd580, 10'd380, COL_OBS_EVEN);
        pix("wrap_before", 10'd579, 10'd380, COL_BG);
        pix("lane3_odd", 10'd395, 10'd380, COL_OBS_ODD);

        x = 10'd300; y = 10'd100;
        ticks(1);
        check_eq("won_state", state, WON);
        check_eq("won_pulse", win, 1'b1);
        check_eq("won_dead", dead, 1'b0);
        step();
        check_eq("won_pulse_end", win, 1'b0);
        check_eq("won_rgb", {8'h00, r, g, b}, {8'h00, COL_WIN});
        pulse_start();
        check_eq("won_to_menu", state, MENU);

        // new game on the ground: lane 0 reaches 230 after 41 ticks
        pulse_start();
        height = 10'd0;
        pix("reload_clear", 10'd580, 10'd380, COL_BG);
        x = 10'd300; y = 10'd100;
        ticks(41);
        check_eq("pre_hit_state", state, PLAY);
        pix("player_h0", 10'd225, 10'd390, COL_PLAYER);
        x = 10'd235; y = 10'd380;
        step();
        check_eq("lost_state", state, LOST);
        check_eq("lost_dead", dead, 1'b1);
        check_eq("lost_win", win, 1'b0);
        check_eq("hit_rgb", {8'h00, r, g, b}, {8'h00, COL_OBS_EVEN});
        step();
        check_eq("dead_end", dead, 1'b0);
        check_eq("lost_rgb", {8'h00, r, g, b}, {8'h00, COL_LOSE});
        pix("lost_any", 10'd10, 10'd10, COL_LOSE);
        pix("lost_out", 10'd650, 10'd10, COL_BLANK);
        pulse_start();
        check_eq("lost_to_menu", state, MENU);

        // start+tick together (tick ignored), then collision on the win tick
        x = 10'd300; y = 10'd100;
        start = 1'b1; game_tick = 1'b1;
        step();
        start = 1'b0; game_tick = 1'b0;
        check_eq("st_tick_state", state, PLAY);
        ticks(73);
        check_eq("pre_tie_state", state, PLAY);
        x = 10'd235; y = 10'd380;
        ticks(1);
        check_eq("tie_state", state, LOST);
        check_eq("tie_dead", dead, 1'b1);
        check_eq("tie_win", win, 1'b0);
        step();
        check_eq("tie_win_after", win, 1'b0);
        pulse_start();

        // asynchronous reset in the middle of a game
        pulse_start();
        x = 10'd300; y = 10'd100;
        ticks(10);
        reset = 1'b0;
        #2;
        check_eq("arst_state", state, MENU);
        check_eq("arst_rgb", {8'h00, r, g, b}, 32'h0);
        check_eq("arst_win", win, 1'b0);
        check_eq("arst_dead", dead, 1'b0);
        step();
        reset = 1'b1;
        pulse_start();
        ticks(10);
        pix("arst_lane0", 10'd540, 10'd380, COL_OBS_EVEN);
        pix("arst_lane0_b", 10'd530, 10'd380, COL_BG);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
